seg7_scan_display: RTL and testbench

//  Reader side of the timer's decimal-counter chain: samples N packed BCD digits

---
 rtl/seg7_scan_display_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 31 +++
 rtl/seg7_scan_display.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_display.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared 7-segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
package seg7_scan_display_pkg;

  localparam logic [6:0] SEG7_0   = 7'h3F;
  localparam logic [6:0] SEG7_1   = 7'h06;
  localparam logic [6:0] SEG7_2   = 7'h5B;
  localparam logic [6:0] SEG7_3   = 7'h4F;
  localparam logic [6:0] SEG7_4   = 7'h66;
  localparam logic [6:0] SEG7_5   = 7'h6D;
  localparam logic [6:0] SEG7_6   = 7'h7D;
  localparam logic [6:0] SEG7_7   = 7'h07;
  localparam logic [6:0] SEG7_8   = 7'h7F;
  localparam logic [6:0] SEG7_9   = 7'h6F;
  localparam logic [6:0] SEG7_A   = 7'h77;
  localparam logic [6:0] SEG7_B   = 7'h7C;
  localparam logic [6:0] SEG7_C   = 7'h39;
  localparam logic [6:0] SEG7_D   = 7'h5E;
  localparam logic [6:0] SEG7_E   = 7'h79;
  localparam logic [6:0] SEG7_F   = 7'h71;
  localparam logic [6:0] SEG7_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit to active-high 7-segment decoder; 10-15 render as A,b,C,d,E,F.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG7_OFF;
    unique case (bcd_i)
      4'h0: seg_o = SEG7_0;
      4'h1: seg_o = SEG7_1;
      4'h2: seg_o = SEG7_2;
      4'h3: seg_o = SEG7_3;
      4'h4: seg_o = SEG7_4;
      4'h5: seg_o = SEG7_5;
      4'h6: seg_o = SEG7_6;
      4'h7: seg_o = SEG7_7;
      4'h8: seg_o = SEG7_8;
      4'h9: seg_o = SEG7_9;
      4'hA: seg_o = SEG7_A;
      4'hB: seg_o = SEG7_B;
      4'hC: seg_o = SEG7_C;
      4'hD: seg_o = SEG7_D;
      4'hE: seg_o = SEG7_E;
      4'hF: seg_o = SEG7_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment scanner: per-frame snapshot of BCD digits, per-slot
// anti-ghost blanking, optional leading-zero suppression, registered outputs.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK_CYC  = 2,
  parameter bit          SEG_ACT_LO = 1'b1,
  parameter bit          DIG_ACT_LO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [4*N_DIGITS-1:0] i_digits,
  input  logic [N_DIGITS-1:0]   i_dots,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_dig,
  output logic                  o_frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(N_DIGITS);

  localparam logic [PW-1:0]       PrescLast = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IdxLast   = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SegOff    = SEG_ACT_LO ? ~SEG7_OFF : SEG7_OFF;
  localparam logic                DpOff     = SEG_ACT_LO;
  localparam logic [N_DIGITS-1:0] DigOff    = DIG_ACT_LO ? {N_DIGITS{1'b1}} : '0;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]   snap_dots_q, snap_dots_d;
  logic                  snap_lz_q, snap_lz_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  frame_done_q, frame_done_d;

  logic                  take_snap;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [3:0]            cur_digit;
  logic                  cur_dot;
  logic                  cur_blank;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_act;
  logic [N_DIGITS-1:0]   dig_on;

  // Scan counters and frame snapshot.
  always_comb begin
    take_snap     = i_enable && (presc_q == '0) && (idx_q == '0);
    snap_digits_d = take_snap ? i_digits   : snap_digits_q;
    snap_dots_d   = take_snap ? i_dots     : snap_dots_q;
    snap_lz_d     = take_snap ? i_blank_lz : snap_lz_q;
    presc_d       = presc_q;
    idx_d         = idx_q;
    frame_done_d  = 1'b0;
    if (!i_enable) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_q == PrescLast) begin
      presc_d      = '0;
      idx_d        = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      frame_done_d = (idx_q == IdxLast);
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Display data is taken from the snapshot value in effect for this cycle, so the
  // first slot of a frame already shows the digits latched on that same edge.
  always_comb begin
    cur_digit = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      blank_mask[k] = snap_lz_d && (k != 0);
      for (int j = k; j < int'(N_DIGITS); j++) begin
        if (snap_digits_d[4*j +: 4] != 4'h0) begin
          blank_mask[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (idx_q == IW'(k)) begin
        cur_digit = snap_digits_d[4*k +: 4];
        cur_dot   = snap_dots_d[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_act = cur_blank ? SEG7_OFF : dec_seg;
    dig_on  = (32'(presc_q) < BLANK_CYC) ? '0 : (N_DIGITS'(1) << idx_q);
    seg_d   = SegOff;
    dp_d    = DpOff;
    dig_d   = DigOff;
    if (i_enable) begin
      seg_d = SEG_ACT_LO ? ~seg_act : seg_act;
      dp_d  = SEG_ACT_LO ? ~cur_dot : cur_dot;
      dig_d = DIG_ACT_LO ? ~dig_on : dig_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dots_q   <= '0;
      snap_lz_q     <= 1'b0;
      seg_q         <= SegOff;
      dp_q          <= DpOff;
      dig_q         <= DigOff;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dots_q   <= snap_dots_d;
      snap_lz_q     <= snap_lz_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_q         <= dig_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_dig        = dig_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: 4 digits, 4-cycle slots, 1 blank cycle, active-low.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [15:0] i_digits;
  logic [3:0]  i_dots;
  logic        i_blank_lz;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_dig;
  logic        o_frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .N_DIGITS   (4),
    .SCAN_DIV   (4),
    .BLANK_CYC  (1),
    .SEG_ACT_LO (1'b1),
    .DIG_ACT_LO (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_digits     (i_digits),
    .i_dots       (i_dots),
    .i_blank_lz   (i_blank_lz),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_dig        (o_dig),
    .o_frame_done (o_frame_done)
  );

  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {dig, seg, dp, frame_done} after the tt-th edge of a frame sequence.
  function automatic logic [12:0] model(input logic [15:0] dg, input logic [3:0] dt,
                                        input logic [3:0] bl, input int tt);
    int         slot;
    int         ph;
    logic [3:0] one;
    logic [3:0] dig;
    logic [6:0] seg;
    slot = (tt / 4) % 4;
    ph   = tt % 4;
    one  = 4'b0001;
    dig  = (ph == 0) ? 4'hF : ~(one << slot);
    seg  = bl[slot] ? 7'h7F : ~seg_hi(dg[4*slot +: 4]);
    return {dig, seg, ~dt[slot], (tt % 16) == 15};
  endfunction

  // During the all-off cycle only o_dig and o_frame_done are defined.
  function automatic logic [12:0] care(input int tt);
    return ((tt % 4) == 0) ? 13'h1E01 : 13'h1FFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b1; i_digits = 16'h1234; i_dots = 4'h0; i_blank_lz = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (o_dig !== 4'b1111) $display("FAIL reset_dig got %b want 1111", o_dig);
    else n_pass++;
    n_checks++;
    if (o_seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", o_seg);
    else n_pass++;
    n_checks++;
    if (o_dp !== 1'b1) $display("FAIL reset_dp got %b want 1", o_dp);
    else n_pass++;
    n_checks++;
    if (o_frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", o_frame_done);
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [12:0] obs;
    logic [12:0] exp_v;
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = model(16'h1234, 4'h0, 4'h0, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL scan t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  task automatic test_snapshot();
    logic [12:0] obs;
    logic [12:0] exp_v;
    for (int i = 0; i < 32; i++) begin
      if (i == 6) i_digits = 16'h5678;
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = model((i < 16) ? 16'h1234 : 16'h5678, 4'h0, 4'h0, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL snapshot t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  task automatic test_blank_lz();
    logic [12:0] obs;
    logic [12:0] exp_v;
    i_digits = 16'h0050; i_blank_lz = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) i_digits = 16'h0000;
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = (i < 16) ? model(16'h0050, 4'h0, 4'b1100, t) : model(16'h0000, 4'h0, 4'b1110, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL blank_lz t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  task automatic test_enable();
    logic [12:0] obs;
    logic [12:0] exp_v;
    for (int i = 0; i < 5; i++) begin
      tick();
      t++;
    end
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {o_dig, o_seg, o_dp, o_frame_done};
      n_checks++;
      if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0})
        $display("FAIL disabled cyc=%0d got %h want %h", i, obs, {4'hF, 7'h7F, 1'b1, 1'b0});
      else n_pass++;
    end
    i_digits = 16'h0B00; i_dots = 4'b0100; i_blank_lz = 1'b0; i_enable = 1'b1;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = model(16'h0B00, 4'b0100, 4'h0, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL reenable t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs;
    logic [12:0] exp_v;
    for (int i = 0; i < 6; i++) begin
      tick();
      t++;
    end
    rst_n = 1'b0;
    tick();
    obs = {o_dig, o_seg, o_dp, o_frame_done};
    n_checks++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_mid got %h want %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0});
    else n_pass++;
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = model(16'h0B00, 4'b0100, 4'h0, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL after_reset t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs;
    logic [12:0] exp_v;
    i_digits = 16'hF9A0; i_dots = 4'b1010; i_blank_lz = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        i_digits = 16'h0C07; i_dots = 4'b0001;
      end
      tick();
      obs   = {o_dig, o_seg, o_dp, o_frame_done};
      exp_v = (i < 16) ? model(16'hF9A0, 4'b1010, 4'h0, t) : model(16'h0C07, 4'b0001, 4'b1000, t);
      n_checks++;
      if (((obs ^ exp_v) & care(t)) !== 13'h0)
        $display("FAIL back_to_back t=%0d got %h want %h", t, obs, exp_v);
      else n_pass++;
      t++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank_lz();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
